// File: rtl/pwm_pkg.sv
// Shared defaults, step codes and ramp state encoding for the PWM ramp monitor.
package pwm_pkg;

  localparam int PERIOD_US_DEF = 100;
  localparam int DUTY_TOL_DEF  = 2;

  localparam logic [2:0] STEP_0    = 3'd0;
  localparam logic [2:0] STEP_25   = 3'd1;
  localparam logic [2:0] STEP_50   = 3'd2;
  localparam logic [2:0] STEP_75   = 3'd3;
  localparam logic [2:0] STEP_100  = 3'd4;
  localparam logic [2:0] STEP_NONE = 3'd7;

  typedef enum logic [2:0] {
    RS_IDLE = 3'd0,
    RS_R25  = 3'd1,
    RS_R50  = 3'd2,
    RS_R75  = 3'd3,
    RS_R100 = 3'd4,
    RS_DONE = 3'd5
  } ramp_state_t;

  function automatic logic [2:0] classify_duty(input logic [6:0] d, input int tol);
    int dv;
    dv = int'(d);
    if (dv <= tol)                          return STEP_0;
    else if (dv >= 25 - tol && dv <= 25 + tol) return STEP_25;
    else if (dv >= 50 - tol && dv <= 50 + tol) return STEP_50;
    else if (dv >= 75 - tol && dv <= 75 + tol) return STEP_75;
    else if (dv >= 100 - tol)               return STEP_100;
    else                                    return STEP_NONE;
  endfunction

endpackage

// File: rtl/pwm_window_meter.sv
// Synchronizes pwm_in, detects rising edges and measures high time per
// PERIOD_US-cycle window; windows re-align to rising edges.
module pwm_window_meter
  import pwm_pkg::*;
#(
  parameter int PERIOD_US = PERIOD_US_DEF
) (
  input  logic       clk_1mhz,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [6:0] duty,
  output logic       duty_valid,
  output logic       period_err
);

  localparam int CW = $clog2(PERIOD_US + 1);

  logic          s_meta, s, s_prev;
  logic [CW-1:0] cnt_q, high_q, cnt_c, high_c;
  logic          locked_q, first, rise, early;

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= pwm_in;
      s      <= s_meta;
      s_prev <= s;
    end
  end

  // cnt_q == 0 marks that the current cycle opens a fresh window
  assign rise   = s & ~s_prev;
  assign first  = (cnt_q == '0);
  assign cnt_c  = first ? CW'(1) : cnt_q + CW'(1);
  assign high_c = first ? CW'(s) : high_q + CW'(s);
  assign early  = rise && !first && (cnt_c < CW'(PERIOD_US));

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      cnt_q      <= '0;
      high_q     <= '0;
      locked_q   <= 1'b0;
      duty       <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      if (early) begin
        // edge cycle becomes cnt=1 of the new window; s is 1 here
        period_err <= locked_q;
        locked_q   <= 1'b1;
        cnt_q      <= CW'(1);
        high_q     <= CW'(1);
      end else begin
        if (first) locked_q <= rise;
        if (cnt_c == CW'(PERIOD_US)) begin
          duty       <= 7'(high_c);
          duty_valid <= 1'b1;
          cnt_q      <= '0;
          high_q     <= '0;
        end else begin
          cnt_q  <= cnt_c;
          high_q <= high_c;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_monitor.sv
// Classifies each measured duty into a step and watches for a held
// 25/50/75/100% ramp, flagging completion with a sticky output.
module pwm_ramp_monitor
  import pwm_pkg::*;
#(
  parameter int PERIOD_US = PERIOD_US_DEF,
  parameter int DUTY_TOL  = DUTY_TOL_DEF,
  parameter int MIN_HOLD  = 2400
) (
  input  logic       clk_1mhz,
  input  logic       reset,
  input  logic       pwm_in,
  input  logic       clear,
  output logic [6:0] duty,
  output logic       duty_valid,
  output logic       period_err,
  output logic [2:0] step,
  output logic       ramp_complete
);

  localparam logic [11:0] HOLD_MIN = 12'(MIN_HOLD);

  ramp_state_t state_q, state_d;
  logic [11:0] hold_q, hold_d;
  logic [2:0]  step_c, want_c, next_c;

  pwm_window_meter #(.PERIOD_US(PERIOD_US)) u_meter (
    .clk_1mhz   (clk_1mhz),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .period_err (period_err)
  );

  assign step_c = classify_duty(duty, DUTY_TOL);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    want_c  = STEP_NONE;
    next_c  = STEP_NONE;
    case (state_q)
      RS_R25:  begin want_c = STEP_25;  next_c = STEP_50;  end
      RS_R50:  begin want_c = STEP_50;  next_c = STEP_75;  end
      RS_R75:  begin want_c = STEP_75;  next_c = STEP_100; end
      RS_R100: want_c = STEP_100;
      default: ;
    endcase

    if (period_err) begin
      state_d = RS_IDLE;
      hold_d  = '0;
    end else if (duty_valid && state_q != RS_DONE) begin
      if (state_q != RS_IDLE && step_c == want_c) begin
        hold_d = (hold_q == '1) ? hold_q : hold_q + 12'd1;
        if (state_q == RS_R100 && hold_d >= HOLD_MIN) state_d = RS_DONE;
      end else if (next_c != STEP_NONE && step_c == next_c && hold_q >= HOLD_MIN) begin
        state_d = ramp_state_t'(state_q + 3'd1);
        hold_d  = 12'd1;
      end else if (step_c == STEP_25) begin
        state_d = RS_R25;
        hold_d  = 12'd1;
      end else begin
        state_d = RS_IDLE;
        hold_d  = '0;
      end
    end

    // clearing a finished ramp rearms the tracker
    if (clear && (state_q == RS_DONE || state_d == RS_DONE)) begin
      state_d = RS_IDLE;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      state_q       <= RS_IDLE;
      hold_q        <= '0;
      step          <= STEP_0;
      ramp_complete <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (duty_valid) step <= step_c;
      if (clear) ramp_complete <= 1'b0;
      else if (state_d == RS_DONE && state_q != RS_DONE) ramp_complete <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_monitor.sv
// Drives aligned PWM periods and compares every duty report against a
// run-length model of duty classification and ramp completion.
module tb_pwm_ramp_monitor;

  localparam int PER = 100;
  localparam int TOL = 2;
  localparam int MH  = 4;

  typedef struct {
    int duty;
    int stp;
    int rc;
  } ev_t;

  logic       clk_1mhz = 1'b0;
  logic       reset    = 1'b1;
  logic       pwm_in   = 1'b0;
  logic       clear    = 1'b0;
  logic [6:0] duty;
  logic       duty_valid, period_err, ramp_complete;
  logic [2:0] step;

  int   checks = 0;
  int   errors = 0;
  int   pe_cnt = 0;
  int   pe_exp = 0;
  int   rc_m   = 0;
  ev_t  act_q[$];
  ev_t  exp_q[$];
  int   hist[$];
  logic pend = 1'b0;
  int   pend_duty = 0;

  pwm_ramp_monitor #(.PERIOD_US(PER), .DUTY_TOL(TOL), .MIN_HOLD(MH)) dut (
    .clk_1mhz      (clk_1mhz),
    .reset         (reset),
    .pwm_in        (pwm_in),
    .clear         (clear),
    .duty          (duty),
    .duty_valid    (duty_valid),
    .period_err    (period_err),
    .step          (step),
    .ramp_complete (ramp_complete)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  // capture each report; step/ramp_complete settle one cycle after duty_valid
  always @(negedge clk_1mhz) begin
    pend      <= (duty_valid === 1'b1);
    pend_duty <= int'(duty);
    if (pend) act_q.push_back('{pend_duty, int'(step), int'(ramp_complete)});
    if (period_err === 1'b1) pe_cnt <= pe_cnt + 1;
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int cls(input int d);
    if (d <= TOL)              return 0;
    if (iabs(d - 25) <= TOL)   return 1;
    if (iabs(d - 50) <= TOL)   return 2;
    if (iabs(d - 75) <= TOL)   return 3;
    if (d >= 100 - TOL)        return 4;
    return 7;
  endfunction

  // ramp seen = adjacent runs of steps 1,2,3,4 each at least MH long
  function automatic int ramp_seen();
    int rv[$];
    int rl[$];
    foreach (hist[i]) begin
      if (rv.size() > 0 && rv[rv.size()-1] == hist[i]) rl[rl.size()-1] = rl[rl.size()-1] + 1;
      else begin
        rv.push_back(hist[i]);
        rl.push_back(1);
      end
    end
    for (int k = 0; k + 3 < rv.size(); k++)
      if (rv[k] == 1 && rv[k+1] == 2 && rv[k+2] == 3 && rv[k+3] == 4 &&
          rl[k] >= MH && rl[k+1] >= MH && rl[k+2] >= MH && rl[k+3] >= MH) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1mhz);
    #1;
  endtask

  task automatic push_expected(input int h);
    int s;
    s = cls(h);
    hist.push_back(s);
    if (ramp_seen() != 0) rc_m = 1;
    exp_q.push_back('{h, s, rc_m});
  endtask

  task automatic check_events();
    ev_t a, e;
    chk("event_count", act_q.size(), exp_q.size());
    chk("period_err_count", pe_cnt, pe_exp);
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk("duty", a.duty, e.duty);
      chk("step", a.stp, e.stp);
      chk("ramp_complete", a.rc, e.rc);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_duty"}, 32'(duty), 0);
    chk({tag, "_duty_valid"}, 32'(duty_valid), 0);
    chk({tag, "_period_err"}, 32'(period_err), 0);
    chk({tag, "_step"}, 32'(step), 0);
    chk({tag, "_ramp_complete"}, 32'(ramp_complete), 0);
  endtask

  // len < PER produces an early edge on the following period start
  task automatic drive_period(input int h, input int len, input bit clr);
    for (int i = 0; i < len; i++) begin
      pwm_in = (i < h);
      if (clr && i == 20) clear = 1'b1;
      tick();
      clear = 1'b0;
      if (i == 8) check_events();
      if (clr && i == 22) begin
        chk("clear_rc", 32'(ramp_complete), 0);
        hist.delete();
        rc_m = 0;
      end
    end
    if (len == PER) push_expected(h);
    else begin
      hist.delete();
      pe_exp++;
    end
  endtask

  task automatic drive_run(input int h, input int n);
    for (int k = 0; k < n; k++) drive_period(h, PER, 1'b0);
  endtask

  task automatic drive_random(input int n);
    int base, h;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 5))
        0: base = 0;
        1: base = 25;
        2: base = 50;
        3: base = 75;
        4: base = 100;
        default: base = int'($urandom_range(0, 100));
      endcase
      h = base + int'($urandom_range(0, 8)) - 4;
      if (h < 0) h = 0;
      if (h > 100) h = 100;
      drive_period(h, PER, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    hist.delete();
    rc_m = 0;
  endtask

  initial begin
    // constant high through reset: one free-window abandon, then 100% windows
    pwm_in = 1'b1;
    do_reset();
    check_zero("reset");
    reset = 1'b0;
    repeat (350) tick();
    repeat (3) push_expected(100);
    check_events();

    pwm_in = 1'b0;
    do_reset();
    check_zero("reset2");
    reset = 1'b0;
    repeat (30) tick();

    // full ramp, then clear while done
    drive_run(25, 4);
    drive_run(50, 4);
    drive_run(75, 4);
    drive_run(100, 4);
    drive_period(50, PER, 1'b1);

    drive_run(25, 3);

    // early edge inside a locked window
    drive_run(50, 2);
    drive_period(30, 60, 1'b0);
    drive_run(50, 2);

    // 50% stage too short
    drive_run(25, 4);
    drive_run(50, 3);
    drive_run(75, 4);
    drive_run(100, 4);

    drive_random(12);

    // reset during the 75% stage
    drive_run(25, 4);
    drive_run(50, 4);
    drive_run(75, 2);
    for (int i = 0; i < 50; i++) begin
      pwm_in = (i < 75);
      tick();
      if (i == 8) check_events();
    end
    pwm_in = 1'b0;
    reset  = 1'b1;
    tick();
    check_zero("midreset");
    reset = 1'b0;
    hist.delete();
    rc_m = 0;
    repeat (95) tick();
    chk("no_early_report", act_q.size(), 0);
    repeat (15) tick();
    push_expected(0);
    check_events();

    drive_random(4);
    repeat (10) tick();
    check_events();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
